// File: rtl/uart_rx_frontend.sv
// UART receive front end: synchronises RX, validates start bits, samples 8N1 frames at mid-bit
// and hands each good byte to the controller as o_rx/o_irq with framing-error and overrun reporting.
module uart_rx_frontend #(
    parameter int CLKS_PER_BIT = 87,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_rxd,
    input  logic       i_rx_finish,
    output logic [7:0] o_rx,
    output logic       o_irq,
    output logic       o_rx_busy,
    output logic       o_frame_err,
    output logic       o_overrun
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic             r_sync1;
    logic             r_sync2;
    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic [7:0]       r_rx;
    logic             r_irq;
    logic             r_busy;
    logic             r_frame_err;
    logic             r_overrun;

    logic             w_half_hit;
    logic             w_full_hit;
    logic [CNT_W-1:0] w_cnt_inc;

    assign w_half_hit = (r_cnt == HALF_M1);
    assign w_full_hit = (r_cnt == FULL_M1);
    assign w_cnt_inc  = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    // Two-flop synchroniser on the asynchronous RX pin, idle-high reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_rxd;
            r_sync2 <= r_sync1;
        end
    end

    // Receive FSM with all status outputs registered alongside the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cnt       <= {CNT_W{1'b0}};
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx        <= 8'h00;
            r_irq       <= 1'b0;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            // A load in STOP below overrides this clear when both coincide.
            if (i_rx_finish && r_irq) begin
                r_irq <= 1'b0;
            end else begin
                r_irq <= r_irq;
            end

            case (r_state)
                ST_IDLE: begin
                    if (!r_sync2) begin
                        r_state <= ST_START;
                        r_cnt   <= {CNT_W{1'b0}};
                        r_busy  <= 1'b1;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_half_hit) begin
                        if (!r_sync2) begin
                            r_frame_err <= 1'b0;
                            r_cnt       <= {CNT_W{1'b0}};
                            r_bit_idx   <= 3'd0;
                            r_state     <= ST_DATA;
                        end else begin
                            r_state     <= ST_IDLE;
                            r_busy      <= 1'b0;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_DATA: begin
                    if (w_full_hit) begin
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_cnt     <= {CNT_W{1'b0}};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_STOP;
                        end else begin
                            r_state <= ST_DATA;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_STOP: begin
                    if (w_full_hit) begin
                        r_cnt <= {CNT_W{1'b0}};
                        if (r_sync2) begin
                            if (!r_irq || i_rx_finish) begin
                                r_rx  <= r_shift;
                                r_irq <= 1'b1;
                            end else begin
                                r_overrun <= 1'b1;
                            end
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= ST_BREAK;
                        end
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_BREAK: begin
                    // Busy stays high with frame_err until the line returns to idle.
                    if (r_sync2) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_BREAK;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_cnt   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign o_rx        = r_rx;
    assign o_irq       = r_irq;
    assign o_rx_busy   = r_busy;
    assign o_frame_err = r_frame_err;
    assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Directed bench for uart_rx_frontend at 8 clocks per bit; delivered bytes are checked against a scoreboard queue.
module tb_uart_rx_frontend;

    localparam int CPB = 8;

    logic       clk;
    logic       rst_n;
    logic       i_rxd;
    logic       i_rx_finish;
    logic [7:0] o_rx;
    logic       o_irq;
    logic       o_rx_busy;
    logic       o_frame_err;
    logic       o_overrun;

    int         total;
    int         bad;
    int         ovr_cnt;
    int         ovr_base;
    int         bcnt;
    logic       mid_busy;
    logic       early_irq;
    logic [7:0] exp_q[$];
    logic [7:0] prev_rx;
    logic       prev_irq;

    uart_rx_frontend #(.CLKS_PER_BIT(CPB), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_rxd       (i_rxd),
        .i_rx_finish (i_rx_finish),
        .o_rx        (o_rx),
        .o_irq       (o_irq),
        .o_rx_busy   (o_rx_busy),
        .o_frame_err (o_frame_err),
        .o_overrun   (o_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: each new byte presentation pops and compares the oldest expected byte.
    always @(negedge clk) begin
        if (o_irq && (!prev_irq || (o_rx != prev_rx))) begin
            check("deliv_pending", {31'd0, (exp_q.size() > 0)}, 32'd1);
            if (exp_q.size() > 0) begin
                check("deliv_byte", {24'd0, o_rx}, {24'd0, exp_q.pop_front()});
            end
        end
        prev_irq = o_irq;
        prev_rx  = o_rx;
    end

    // Count overrun pulse cycles.
    always @(negedge clk) begin
        if (o_overrun === 1'b1) ovr_cnt++;
    end

    task automatic send(input logic [7:0] b, input logic stop_bit, input int fin_cyc, input int abort_cyc);
        int bi;
        for (int c = 0; c < 10 * CPB; c++) begin
            @(negedge clk);
            if (c == abort_cyc) return;
            if (c == 40) mid_busy = o_rx_busy;
            if (c == 76) early_irq = o_irq;
            bi = c / CPB;
            if (bi == 0)      i_rxd = 1'b0;
            else if (bi == 9) i_rxd = stop_bit;
            else              i_rxd = b[bi-1];
            i_rx_finish = (c == fin_cyc);
        end
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            i_rxd       = 1'b1;
            i_rx_finish = 1'b0;
        end
    endtask

    task automatic finish_pulse();
        @(negedge clk);
        i_rx_finish = 1'b1;
        @(negedge clk);
        i_rx_finish = 1'b0;
        check("irq_clear", {31'd0, o_irq}, 32'd0);
    endtask

    initial begin
        total = 0; bad = 0; ovr_cnt = 0;
        prev_rx = 8'h00; prev_irq = 1'b0;
        mid_busy = 1'b0; early_irq = 1'b0;
        rst_n = 1'b0; i_rxd = 1'b1; i_rx_finish = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_rx", {24'd0, o_rx}, 32'd0);
        check("rst_irq", {31'd0, o_irq}, 32'd0);
        check("rst_busy", {31'd0, o_rx_busy}, 32'd0);
        check("rst_ferr", {31'd0, o_frame_err}, 32'd0);
        check("rst_ovr", {31'd0, o_overrun}, 32'd0);
        rst_n = 1'b1;
        idle(10);

        // Basic frame 0xA5
        exp_q.push_back(8'hA5);
        send(8'hA5, 1'b1, -1, -1);
        check("a5_mid_busy", {31'd0, mid_busy}, 32'd1);
        check("a5_not_early", {31'd0, early_irq}, 32'd0);
        check("a5_irq", {31'd0, o_irq}, 32'd1);
        check("a5_ferr", {31'd0, o_frame_err}, 32'd0);
        idle(5);
        finish_pulse();
        idle(5);

        // Two-cycle low glitch
        @(negedge clk); i_rxd = 1'b0;
        bcnt = 0;
        @(negedge clk); if (o_rx_busy) bcnt++;
        @(negedge clk); if (o_rx_busy) bcnt++; i_rxd = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (o_rx_busy) bcnt++;
        end
        check("glitch_busy_len", {31'd0, (bcnt >= 3 && bcnt <= 7)}, 32'd1);
        check("glitch_irq", {31'd0, o_irq}, 32'd0);
        check("glitch_rx", {24'd0, o_rx}, 32'h0000_00A5);
        check("glitch_ferr", {31'd0, o_frame_err}, 32'd0);

        // Framing error with line held low, then recovery on 0x11
        send(8'h3C, 1'b0, -1, -1);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            i_rxd = 1'b0;
        end
        check("brk_ferr", {31'd0, o_frame_err}, 32'd1);
        check("brk_busy", {31'd0, o_rx_busy}, 32'd1);
        check("brk_irq", {31'd0, o_irq}, 32'd0);
        check("brk_rx", {24'd0, o_rx}, 32'h0000_00A5);
        idle(4);
        check("brk_exit_busy", {31'd0, o_rx_busy}, 32'd0);
        check("brk_ferr_hold", {31'd0, o_frame_err}, 32'd1);
        idle(5);
        exp_q.push_back(8'h11);
        send(8'h11, 1'b1, -1, -1);
        check("f11_ferr_clr", {31'd0, o_frame_err}, 32'd0);
        check("f11_irq", {31'd0, o_irq}, 32'd1);
        finish_pulse();
        idle(5);

        // Overrun: 0x02 arrives while 0x01 is unconsumed
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1, -1, -1);
        idle(5);
        ovr_base = ovr_cnt;
        send(8'h02, 1'b1, -1, -1);
        idle(5);
        check("ovr_pulses", ovr_cnt - ovr_base, 32'd1);
        check("ovr_rx", {24'd0, o_rx}, 32'h0000_0001);
        check("ovr_irq", {31'd0, o_irq}, 32'd1);
        finish_pulse();
        idle(5);

        // Back-to-back 0x55/0xAA with finish on the 0xAA stop-sample cycle
        ovr_base = ovr_cnt;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        send(8'h55, 1'b1, -1, -1);
        send(8'hAA, 1'b1, 78, -1);
        idle(3);
        check("b2b_irq", {31'd0, o_irq}, 32'd1);
        check("b2b_rx", {24'd0, o_rx}, 32'h0000_00AA);
        check("b2b_no_ovr", ovr_cnt - ovr_base, 32'd0);
        idle(5);

        // Reset in the middle of a 0xFF frame
        send(8'hFF, 1'b1, -1, 40);
        rst_n = 1'b0;
        #1;
        check("mrst_rx", {24'd0, o_rx}, 32'd0);
        check("mrst_irq", {31'd0, o_irq}, 32'd0);
        check("mrst_busy", {31'd0, o_rx_busy}, 32'd0);
        check("mrst_ferr", {31'd0, o_frame_err}, 32'd0);
        check("mrst_ovr", {31'd0, o_overrun}, 32'd0);
        repeat (2) @(negedge clk);
        i_rxd = 1'b1;
        rst_n = 1'b1;
        idle(100);
        check("post_rst_irq", {31'd0, o_irq}, 32'd0);
        exp_q.push_back(8'h7E);
        send(8'h7E, 1'b1, -1, -1);
        check("f7e_irq", {31'd0, o_irq}, 32'd1);
        finish_pulse();
        idle(5);

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_frontend.md
Name: uart_rx_frontend

Overview:
Serial receive front end of the user-project UART. It synchronises the external RX pin, detects and validates start bits, and samples 8N1 frames at mid-bit using a clock-divider counter. Each completed byte is presented to the UART controller's receive side as o_rx plus a level o_irq, held until the controller returns its rx_finish pulse. The block also reports receive activity (o_rx_busy), framing errors and overruns.

Parameters:
CLKS_PER_BIT, 87, clock cycles per bit period (integer, >= 4).
CNT_W, 16, width of the bit-period counter; must hold CLKS_PER_BIT-1.

Ports:
clk  in  1  system clock, only clock
rst_n  in  1  asynchronous active-low reset
i_rxd  in  1  raw serial input, idle high, asynchronous to clk
i_rx_finish  in  1  one-cycle pulse from controller: current byte consumed
o_rx  out  8  last good received byte
o_irq  out  1  byte available (level), cleared by i_rx_finish
o_rx_busy  out  1  frame reception in progress
o_frame_err  out  1  stop bit sampled low (see rules)
o_overrun  out  1  one-cycle pulse: good byte dropped because o_irq still set

Behaviour:
- Reset (async, rst_n low): o_rx=8'h00, o_irq=0, o_rx_busy=0, o_frame_err=0, o_overrun=0, state=IDLE, counter=0, bit index=0. Both synchroniser flops reset to 1. Reset mid-frame aborts the frame; no partial byte is ever output.
- Synchroniser: two flops on i_rxd; every FSM decision uses the second flop (rxs). Input-to-rxs latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE: busy=0. If rxs==0: go to START, counter=0.
- START: busy=1. Counter increments each cycle. At counter==CLKS_PER_BIT/2-1 (integer division), sample rxs:
  - rxs==0: valid start. Clear o_frame_err, counter=0, bit index=0, go to DATA.
  - rxs==1: glitch. Go to IDLE; no flags change.
- DATA: busy=1. At counter==CLKS_PER_BIT-1: shift rxs into the data register LSB-first (bit0 received first), counter=0, bit index+1. After the 8th sample, go to STOP.
- STOP: busy=1. At counter==CLKS_PER_BIT-1, sample rxs:
  - rxs==1, o_irq==0 or i_rx_finish==1 in the same cycle: next cycle o_rx=shift data and o_irq=1. Go to IDLE.
  - rxs==1, o_irq==1 and no i_rx_finish: byte dropped, o_rx unchanged, o_overrun pulses 1 cycle. Go to IDLE.
  - rxs==0: o_frame_err=1, byte dropped, o_rx and o_irq unchanged. Go to BREAK.
- BREAK: busy stays 1 while frame_err=1, so the controller sees frame_err&&busy. Exit to IDLE on the first cycle rxs==1; busy drops then. o_frame_err holds until the next valid start (START sample) or reset.
- o_irq clears on the cycle after i_rx_finish==1. If the finish and a new good-stop sample coincide, the new byte is loaded, o_irq stays 1 and there is no overrun. i_rx_finish while o_irq==0 is ignored.
- Latency: the byte appears 1 cycle after the stop-bit sample point, i.e. 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT cycles (±1) after the falling edge on i_rxd.
- Back-to-back frames: because the FSM returns to IDLE at mid-stop-bit, a start bit immediately after the stop bit is accepted.

Test Plan:
- CLKS_PER_BIT=8; send 0xA5 (start, 1,0,1,0,0,1,0,1, stop=1) -> o_rx_busy high during frame; o_irq rises ~77 cycles after edge with o_rx=8'hA5; o_frame_err=0; pulse i_rx_finish -> o_irq=0 next cycle.
- Low glitch of 2 cycles on idle i_rxd -> FSM returns to IDLE at half-bit sample; o_irq, o_rx, o_frame_err unchanged; busy high only ~6 cycles.
- Send 0x3C with stop bit=0, line held low 20 cycles -> o_frame_err=1 and o_rx_busy=1 until line high, o_irq stays 0, o_rx keeps previous value; next valid frame 0x11 clears o_frame_err at its start sample and delivers 8'h11.
- Send 0x01, no i_rx_finish, then 0x02 -> o_overrun pulses exactly 1 cycle, o_rx stays 8'h01, o_irq stays 1.
- Send 0x55 then 0xAA back-to-back with i_rx_finish timed on the 0xAA stop-sample cycle -> o_rx=8'hAA, o_irq=1, no overrun.
- Assert rst_n low mid-DATA of 0xFF -> all outputs 0 immediately; after release an idle line gives no o_irq; next frame 0x7E received correctly.
